// File: rtl/gate_stimulus_sequencer_if.sv
// Signal bundle between the push-button stimulus sequencer and its environment.
// The master drives the raw controls; the slave (sequencer) drives the vector and strobes.
interface gate_stimulus_sequencer_if;
  logic       iBtnStep;
  logic       iClear;
  logic       iAuto;
  logic       oA;
  logic       oB;
  logic       oC;
  logic [2:0] oIndex;
  logic       oStep;
  logic       oWrap;

  modport master (
    output iBtnStep, iClear, iAuto,
    input  oA, oB, oC, oIndex, oStep, oWrap
  );

  modport slave (
    input  iBtnStep, iClear, iAuto,
    output oA, oB, oC, oIndex, oStep, oWrap
  );
endinterface

// File: rtl/gate_stimulus_sequencer.sv
// Debounced push-button stepper that walks a 3-bit vector 000..111 for the gate bank.
// Optional auto-run timer is compiled in when AUTO_RUN_EN is defined.
module gate_stimulus_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input logic                       iClk,
  input logic                       iRst_n,
  gate_stimulus_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } debounceState_t;

  logic [1:0]     btnSyncQ;
  logic [1:0]     clrSyncQ;
  logic           btnS;
  logic           clrS;
  debounceState_t state;
  debounceState_t stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic           accept;
  logic           stepReq;
  logic [2:0]     index;
  logic           stepQ;
  logic           wrapQ;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      btnSyncQ <= '0;
      clrSyncQ <= '0;
    end else begin
      btnSyncQ <= {btnSyncQ[0], bus.iBtnStep};
      clrSyncQ <= {clrSyncQ[0], bus.iClear};
    end
  end

  assign btnS = btnSyncQ[1];
  assign clrS = clrSyncQ[1];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // NOTE: defaults first so no path through always_comb leaves a signal unassigned (no latch).
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (btnS) begin
          stateNext = PRESS_WAIT;
          cntNext   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btnS) begin
          stateNext = IDLE;
        end else if (cnt == CNT_LAST) begin
          stateNext = PRESSED;
          accept    = 1'b1;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btnS) begin
          stateNext = RELEASE_WAIT;
          cntNext   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btnS) begin
          stateNext = PRESSED;
        end else if (cnt == CNT_LAST) begin
          stateNext = IDLE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

`ifdef AUTO_RUN_EN
  localparam int TMR_W = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic [1:0]       autoSyncQ;
  logic             autoS;
  logic [TMR_W-1:0] timer;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      autoSyncQ <= '0;
      timer     <= '0;
    end else begin
      autoSyncQ <= {autoSyncQ[0], bus.iAuto};
      if (!autoS || clrS || timer == TMR_LAST) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign autoS = autoSyncQ[1];

  // Auto mode owns the stepping; debounced presses are dropped while it runs.
  assign stepReq = autoS ? (timer == TMR_LAST) : accept;
`else
  assign stepReq = accept;
`endif

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      index <= '0;
      stepQ <= 1'b0;
      wrapQ <= 1'b0;
    end else if (clrS) begin
      index <= '0;
      stepQ <= 1'b0;
      wrapQ <= 1'b0;
    end else if (stepReq) begin
      index <= index + 3'd1;
      stepQ <= 1'b1;
      wrapQ <= (index == 3'd7);
    end else begin
      stepQ <= 1'b0;
      wrapQ <= 1'b0;
    end
  end

  assign bus.oA     = index[2];
  assign bus.oB     = index[1];
  assign bus.oC     = index[0];
  assign bus.oIndex = index;
  assign bus.oStep  = stepQ;
  assign bus.oWrap  = wrapQ;

endmodule

// File: tb/tb_gate_stimulus_sequencer.sv
// Directed bench for gate_stimulus_sequencer (DEBOUNCE_CYCLES=4, AUTO_PERIOD=8).
// Auto-run checks are included when AUTO_RUN_EN is defined.
module tb_gate_stimulus_sequencer;

  logic iClk;
  logic iRst_n;
  int   compared;
  int   mismatched;

  gate_stimulus_sequencer_if bus ();

  gate_stimulus_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .AUTO_PERIOD     (8)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOut(input string tag, input logic [2:0] idx, input logic step, input logic wrap);
    check({tag, ".index"}, {5'd0, bus.oIndex}, {5'd0, idx});
    check({tag, ".abc"},   {5'd0, bus.oA, bus.oB, bus.oC}, {5'd0, idx});
    check({tag, ".step"},  {7'd0, bus.oStep}, {7'd0, step});
    check({tag, ".wrap"},  {7'd0, bus.oWrap}, {7'd0, wrap});
  endtask

  // Press from idle: accept lands on the 7th edge after the raw rise, then release fully.
  task automatic doPress(input string tag, input logic [2:0] prevIdx, input logic [2:0] newIdx,
                         input logic wrap);
    bus.iBtnStep = 1'b1;
    repeat (6) begin
      tick();
      checkOut({tag, ".quiet"}, prevIdx, 1'b0, 1'b0);
    end
    tick();
    checkOut({tag, ".accept"}, newIdx, 1'b1, wrap);
    tick();
    checkOut({tag, ".after"}, newIdx, 1'b0, 1'b0);
    bus.iBtnStep = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    iRst_n       = 1'b0;
    bus.iBtnStep = 1'b0;
    bus.iClear   = 1'b0;
    bus.iAuto    = 1'b0;

    // Reset held while every input toggles.
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.iBtnStep = i[0];
      bus.iClear   = i[1];
      bus.iAuto    = ~i[0];
      checkOut("reset_held", 3'd0, 1'b0, 1'b0);
    end
    bus.iBtnStep = 1'b0;
    bus.iClear   = 1'b0;
    bus.iAuto    = 1'b0;
    #2;
    iRst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkOut("post_reset_idle", 3'd0, 1'b0, 1'b0);
    end

    // Clean press held for 50 cycles: single step only.
    bus.iBtnStep = 1'b1;
    repeat (6) begin
      tick();
      checkOut("clean.quiet", 3'd0, 1'b0, 1'b0);
    end
    tick();
    checkOut("clean.accept", 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOut("clean.hold", 3'd1, 1'b0, 1'b0);
    end
    bus.iBtnStep = 1'b0;
    repeat (8) tick();

    // Bounce: three 2-cycle pulses with 2-cycle gaps are rejected.
    for (int p = 0; p < 3; p++) begin
      bus.iBtnStep = 1'b1;
      repeat (2) begin
        tick();
        checkOut("bounce", 3'd1, 1'b0, 1'b0);
      end
      bus.iBtnStep = 1'b0;
      repeat (2) begin
        tick();
        checkOut("bounce", 3'd1, 1'b0, 1'b0);
      end
    end
    repeat (8) begin
      tick();
      checkOut("bounce.settle", 3'd1, 1'b0, 1'b0);
    end
    doPress("after_bounce", 3'd1, 3'd2, 1'b0);

    // Clear latency: index forced to 0 on the third edge after assertion.
    bus.iClear = 1'b1;
    repeat (2) begin
      tick();
      checkOut("clear.latency", 3'd2, 1'b0, 1'b0);
    end
    tick();
    checkOut("clear.applied", 3'd0, 1'b0, 1'b0);
    bus.iClear = 1'b0;
    repeat (3) tick();

    // Full walk: 1..7,0 with wrap only on the eighth step.
    doPress("walk1", 3'd0, 3'd1, 1'b0);
    doPress("walk2", 3'd1, 3'd2, 1'b0);
    doPress("walk3", 3'd2, 3'd3, 1'b0);
    doPress("walk4", 3'd3, 3'd4, 1'b0);
    doPress("walk5", 3'd4, 3'd5, 1'b0);
    doPress("walk6", 3'd5, 3'd6, 1'b0);
    doPress("walk7", 3'd6, 3'd7, 1'b0);
    doPress("walk8", 3'd7, 3'd0, 1'b1);

    // Advance to 5, then let clear land on the same edge as an accept.
    doPress("to5a", 3'd0, 3'd1, 1'b0);
    doPress("to5b", 3'd1, 3'd2, 1'b0);
    doPress("to5c", 3'd2, 3'd3, 1'b0);
    doPress("to5d", 3'd3, 3'd4, 1'b0);
    doPress("to5e", 3'd4, 3'd5, 1'b0);
    bus.iBtnStep = 1'b1;
    repeat (4) tick();
    bus.iClear = 1'b1;
    repeat (2) begin
      tick();
      checkOut("race.before", 3'd5, 1'b0, 1'b0);
    end
    tick();
    checkOut("race.clear_wins", 3'd0, 1'b0, 1'b0);
    tick();
    checkOut("race.no_late_step", 3'd0, 1'b0, 1'b0);
    bus.iBtnStep = 1'b0;
    repeat (8) tick();
    bus.iClear = 1'b0;
    repeat (3) tick();
    doPress("after_clear", 3'd0, 3'd1, 1'b0);

`ifdef AUTO_RUN_EN
    // Auto run: first step on the 10th edge after iAuto rises, then every 8 edges.
    bus.iAuto = 1'b1;
    repeat (9) begin
      tick();
      checkOut("auto.first_wait", 3'd1, 1'b0, 1'b0);
    end
    for (int s = 0; s < 8; s++) begin
      tick();
      checkOut("auto.step", 3'(2 + s), 1'b1, (s == 6));
      if (s < 7) begin
        repeat (7) begin
          tick();
          checkOut("auto.gap", 3'(2 + s), 1'b0, 1'b0);
        end
      end
    end
    repeat (3) tick();
    iRst_n = 1'b0;
    #1;
    checkOut("auto.async_reset", 3'd0, 1'b0, 1'b0);
    #2;
    iRst_n = 1'b1;
    repeat (9) begin
      tick();
      checkOut("auto.restart_wait", 3'd0, 1'b0, 1'b0);
    end
    tick();
    checkOut("auto.restart_step", 3'd1, 1'b1, 1'b0);
    bus.iAuto = 1'b0;
    repeat (3) tick();
`else
    // Without the auto timer, iAuto has no effect.
    bus.iAuto = 1'b1;
    repeat (12) begin
      tick();
      checkOut("auto_ignored", 3'd1, 1'b0, 1'b0);
    end
    bus.iAuto = 1'b0;
    repeat (3) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
